framebuffer_arbiter: RTL and testbench

Shares one single-port 12-bit framebuffer RAM between three requesters: display scan-out reads, a pixel-write client, and a built-in full-screen clear engine.
- Sits between the VGA display controller (scan-out, fixed deadline) and drawing logic.
- Guarantees scan-out never stalls; drawing traffic uses every RAM cycle the display leaves idle.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/fb_clear_engine.sv | 78 +++++++
 rtl/framebuffer_arbiter.sv | 105 ++++++++++
 tb/tb_framebuffer_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the framebuffer datapath.
// Holds the default screen geometry, the 12-bit {R,G,B} colour type,
// the arbiter state encoding and the last linear pixel address.
package vga_pkg;

    localparam int FB_WIDTH     = 640;
    localparam int FB_HEIGHT    = 480;
    localparam int FB_ADDR_W    = 19;
    localparam int FB_LAST_ADDR = FB_WIDTH * FB_HEIGHT - 1;

    // 4 bits per channel, red in the top nibble.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// fb_clear_engine: full-screen fill sequencer.
// Ports:
//   pixel_clock  clock, rising edge
//   reset        synchronous, active-high
//   start        request a clear (ignored while one is running)
//   fill_color   colour latched together with start
//   grant        the arbiter let this engine use the RAM this cycle
//   busy         clear in progress
//   done         one-cycle pulse after the last pixel has been written
//   wr_addr      address of the pixel to write when granted
//   wr_data      colour to write when granted
module fb_clear_engine
    import vga_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              start,
    input  logic [11:0]       fill_color,
    input  logic              grant,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    arb_state_t        state;
    logic [ADDR_W-1:0] count;
    color_t            color;

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        count <= '0;
                    end
                end
                CLEAR: begin
                    // The counter only moves when the display left the RAM free.
                    if (grant) begin
                        if (count == LAST_ADDR) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fill colour is plain data: captured on an accepted start, never reset.
    always_ff @(posedge pixel_clock) begin
        if (state == IDLE && start) begin
            color <= fill_color;
        end
    end

    assign busy    = (state == CLEAR);
    assign wr_addr = count;
    assign wr_data = color;

endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares one single-port 12-bit framebuffer RAM between
// display scan-out reads, a pixel-write client and the clear engine.
// Priority each cycle: display read > clear engine > pixel write.
// Ports:
//   pixel_clock, reset                     clock / synchronous active-high reset
//   rd_req, rd_addr, rd_data, rd_valid     display read port (1-cycle latency)
//   wr_valid, wr_ready, wr_x, wr_y, wr_color  pixel write handshake
//   clear_start, clear_color, clear_busy, clear_done  clear engine control
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata    RAM side
module framebuffer_arbiter
    import vga_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [11:0]       rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [8:0]        wr_y,
    input  logic [11:0]       wr_color,
    input  logic              clear_start,
    input  logic [11:0]       clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata
);

    logic              clr_busy;
    logic              clr_grant;
    logic [ADDR_W-1:0] clr_addr;
    logic [11:0]       clr_data;
    logic              wr_in_range;
    logic [ADDR_W-1:0] wr_lin_addr;
    logic              rd_vld_p1;

    fb_clear_engine #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .start       (clear_start),
        .fill_color  (clear_color),
        .grant       (clr_grant),
        .busy        (clr_busy),
        .done        (clear_done),
        .wr_addr     (clr_addr),
        .wr_data     (clr_data)
    );

    // Nothing touches the RAM while reset is held, even mid-clear.
    assign clr_grant = !reset && clr_busy && !rd_req;
    assign wr_ready  = !reset && !clr_busy && !rd_req;

    // Off-screen writes still complete the handshake but never reach the RAM.
    assign wr_in_range = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    assign wr_lin_addr = ADDR_W'(wr_y) * ADDR_W'(WIDTH) + ADDR_W'(wr_x);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset && rd_req) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (clr_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = clr_data;
        end else if (wr_valid && wr_ready && wr_in_range) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_lin_addr;
            mem_wdata = wr_color;
        end
    end

    // Stage p0 -> p1: read granted this cycle, RAM data returns next cycle.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_req;
        end
    end

    assign rd_valid   = rd_vld_p1;
    assign rd_data    = mem_rdata;
    assign clear_busy = clr_busy;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Self-checking bench for framebuffer_arbiter on a reduced 64x48 screen.
module tb_framebuffer_arbiter;

    localparam int W    = 64;
    localparam int H    = 48;
    localparam int AW   = 12;
    localparam int NPIX = W * H;

    logic          pixel_clock = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [11:0]   rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [9:0]    wr_x;
    logic [8:0]    wr_y;
    logic [11:0]   wr_color;
    logic          clear_start;
    logic [11:0]   clear_color;
    logic          clear_busy;
    logic          clear_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_wdata;
    logic [11:0]   mem_rdata;

    always #5 pixel_clock = ~pixel_clock;

    framebuffer_arbiter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    function automatic logic [11:0] pat(int i);
        return 12'(i * 7 + 3);
    endfunction

    // RAM model: 1-cycle read latency, write on enable+we.
    logic [11:0] ram     [0:4095];
    logic [11:0] exp_mem [0:4095];
    logic        ram_load;

    always @(posedge pixel_clock) begin
        if (ram_load) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic scan(input string name);
        int n = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== exp_mem[i]) n++;
        chk(name, n, 0);
    endtask

    // Read scoreboard: expectation pushed when a read is granted, popped on rd_valid.
    logic [11:0] sb_q[$];
    logic        mon_g;
    logic [11:0] mon_e;

    always @(posedge pixel_clock) begin
        mon_g = rd_req && !reset;
        if (mon_g) sb_q.push_back(exp_mem[rd_addr]);
        #1;
        chk("rd_valid", rd_valid, mon_g);
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_sb_empty: got rd_valid=1 required no pending read");
            end else begin
                mon_e = sb_q.pop_front();
                chk("rd_data", rd_data, mon_e);
            end
        end else begin
            sb_q.delete();
        end
    end

    typedef struct {
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          wr_valid;
        logic [9:0]    x;
        logic [8:0]    y;
        logic [11:0]   color;
        logic          e_ready;
        logic          e_en;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [11:0]   e_wdata;
    } vec_t;

    vec_t vecs[8];

    int busy_cyc;
    int reads;
    int done_early;
    int rdy_cnt;
    int guard;
    bit tog;

    initial begin
        reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0;
        wr_x = '0; wr_y = '0; wr_color = '0; clear_start = 1'b0; clear_color = '0;
        ram_load = 1'b1;
        for (int i = 0; i < 4096; i++) exp_mem[i] = pat(i);

        vecs[0] = '{1'b0, 12'd0,    1'b1, 10'd63, 9'd47, 12'hF0A, 1'b1, 1'b1, 1'b1, 12'd3071, 12'hF0A};
        vecs[1] = '{1'b0, 12'd0,    1'b1, 10'd64, 9'd0,  12'h111, 1'b1, 1'b0, 1'b0, 12'd0,    12'h000};
        vecs[2] = '{1'b0, 12'd0,    1'b1, 10'd0,  9'd48, 12'h222, 1'b1, 1'b0, 1'b0, 12'd0,    12'h000};
        vecs[3] = '{1'b1, 12'd5,    1'b1, 10'd1,  9'd0,  12'h333, 1'b0, 1'b1, 1'b0, 12'd5,    12'h000};
        vecs[4] = '{1'b0, 12'd0,    1'b1, 10'd0,  9'd0,  12'h7E1, 1'b1, 1'b1, 1'b1, 12'd0,    12'h7E1};
        vecs[5] = '{1'b0, 12'd0,    1'b0, 10'd5,  9'd5,  12'h444, 1'b1, 1'b0, 1'b0, 12'd0,    12'h000};
        vecs[6] = '{1'b0, 12'd0,    1'b1, 10'd10, 9'd2,  12'h0C3, 1'b1, 1'b1, 1'b1, 12'd138,  12'h0C3};
        vecs[7] = '{1'b1, 12'd3071, 1'b0, 10'd0,  9'd0,  12'h000, 1'b0, 1'b1, 1'b0, 12'd3071, 12'h000};

        @(negedge pixel_clock);
        ram_load = 1'b0;

        // Reset state, with a write offered to show wr_ready stays low.
        @(negedge pixel_clock);
        wr_valid = 1'b1;
        #1;
        chk("rst_rd_valid",   rd_valid,   0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_wr_ready",   wr_ready,   0);
        chk("rst_mem_en",     mem_en,     0);
        chk("rst_mem_we",     mem_we,     0);
        chk("rst_mem_addr",   mem_addr,   0);
        chk("rst_mem_wdata",  mem_wdata,  0);
        wr_valid = 1'b0;
        @(negedge pixel_clock);
        reset = 1'b0;

        // Three back-to-back display reads of address 5.
        for (int k = 0; k < 3; k++) begin
            @(negedge pixel_clock);
            rd_req = 1'b1; rd_addr = 12'd5;
            #1;
            chk("rd3_wr_ready", wr_ready, 0);
            chk("rd3_mem_en",   mem_en,   1);
            chk("rd3_mem_we",   mem_we,   0);
            chk("rd3_mem_addr", mem_addr, 5);
        end
        @(negedge pixel_clock);
        rd_req = 1'b0;
        #1;
        chk("post_rd_wr_ready", wr_ready, 1);

        // Table of single-cycle arbitration cases in IDLE.
        for (int v = 0; v < 8; v++) begin
            @(negedge pixel_clock);
            rd_req = vecs[v].rd_req; rd_addr = vecs[v].rd_addr;
            wr_valid = vecs[v].wr_valid; wr_x = vecs[v].x; wr_y = vecs[v].y;
            wr_color = vecs[v].color;
            if (vecs[v].wr_valid && !vecs[v].rd_req && vecs[v].x < W && vecs[v].y < H)
                exp_mem[int'(vecs[v].y) * W + int'(vecs[v].x)] = vecs[v].color;
            #1;
            chk($sformatf("vec%0d_wr_ready", v),  wr_ready,  vecs[v].e_ready);
            chk($sformatf("vec%0d_mem_en", v),    mem_en,    vecs[v].e_en);
            chk($sformatf("vec%0d_mem_we", v),    mem_we,    vecs[v].e_we);
            chk($sformatf("vec%0d_mem_addr", v),  mem_addr,  vecs[v].e_addr);
            chk($sformatf("vec%0d_mem_wdata", v), mem_wdata, vecs[v].e_wdata);
        end
        @(negedge pixel_clock);
        rd_req = 1'b0; wr_valid = 1'b0;
        #1;
        scan("vec_ram");
        chk("vec_ram_3071", ram[3071], 12'hF0A);

        // Full clear, started together with a read, reads toggled throughout.
        @(negedge pixel_clock);
        clear_start = 1'b1; clear_color = 12'h00F; rd_req = 1'b1; rd_addr = 12'd3071;
        #1;
        chk("clr_start_rd_en", mem_en, 1);
        chk("clr_start_rd_we", mem_we, 0);
        chk("clr_start_busy",  clear_busy, 0);
        @(negedge pixel_clock);
        clear_start = 1'b0; clear_color = 12'h000;
        wr_valid = 1'b1; wr_x = 10'd0; wr_y = 9'd0; wr_color = 12'hBAD;
        busy_cyc = 0; reads = 0; done_early = 0; rdy_cnt = 0; guard = 0; tog = 1'b1;
        while (clear_busy && guard < 10000) begin
            busy_cyc++;
            tog = !tog;
            rd_req = tog;
            if (tog) reads++;
            #1;
            if (clear_done) done_early++;
            if (wr_ready) rdy_cnt++;
            @(negedge pixel_clock);
            guard++;
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        #1;
        chk("clr_cycles",        busy_cyc,   NPIX + reads);
        chk("clr_done_pulse",    clear_done, 1);
        chk("clr_done_early",    done_early, 0);
        chk("clr_wr_ready_busy", rdy_cnt,    0);
        for (int i = 0; i < NPIX; i++) exp_mem[i] = 12'h00F;
        @(negedge pixel_clock);
        #1;
        chk("clr_done_single", clear_done, 0);
        scan("clr_all");

        // Reset when the clear counter reaches 1000.
        @(negedge pixel_clock);
        clear_start = 1'b1; clear_color = 12'h5A5;
        @(negedge pixel_clock);
        clear_start = 1'b0;
        repeat (1000) @(negedge pixel_clock);
        #1;
        chk("mid_busy",     clear_busy, 1);
        chk("mid_mem_addr", mem_addr,   1000);
        chk("mid_mem_we",   mem_we,     1);
        reset = 1'b1;
        @(negedge pixel_clock);
        #1;
        chk("mid_rst_busy",   clear_busy, 0);
        chk("mid_rst_done",   clear_done, 0);
        chk("mid_rst_mem_en", mem_en,     0);
        reset = 1'b0;
        @(negedge pixel_clock);
        #1;
        chk("mid_rst_done2", clear_done, 0);
        for (int i = 0; i < 1000; i++) exp_mem[i] = 12'h5A5;
        chk("mid_ram_999",  ram[999],  12'h5A5);
        chk("mid_ram_1000", ram[1000], 12'h00F);
        scan("mid_partial");

        // clear_start and a pixel write in the same IDLE cycle.
        @(negedge pixel_clock);
        clear_start = 1'b1; clear_color = 12'h123;
        wr_valid = 1'b1; wr_x = 10'd1; wr_y = 9'd1; wr_color = 12'hABC;
        #1;
        chk("sim_wr_ready",  wr_ready,   1);
        chk("sim_mem_we",    mem_we,     1);
        chk("sim_mem_addr",  mem_addr,   65);
        chk("sim_mem_wdata", mem_wdata,  12'hABC);
        chk("sim_busy0",     clear_busy, 0);
        @(negedge pixel_clock);
        clear_start = 1'b0; wr_valid = 1'b0;
        #1;
        chk("sim_busy1",      clear_busy, 1);
        chk("sim_ram_65",     ram[65],    12'hABC);
        chk("sim_clr_addr0",  mem_addr,   0);
        chk("sim_clr_wdata",  mem_wdata,  12'h123);
        busy_cyc = 0;
        while (clear_busy && busy_cyc < 10000) begin
            busy_cyc++;
            @(negedge pixel_clock);
        end
        #1;
        chk("sim_clr_cycles", busy_cyc,   NPIX);
        chk("sim_clr_done",   clear_done, 1);
        @(negedge pixel_clock);
        chk("sim_ram_65_ovr", ram[65], 12'h123);
        for (int i = 0; i < NPIX; i++) exp_mem[i] = 12'h123;
        scan("sim_all");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
